// File: rtl/apb_arb_master.sv
// rtl/apb_arb_master.sv - two-requester round-robin APB master with access timeout
module apb_arb_master #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 8,
  parameter int TIMEOUT    = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [1:0]              req_valid,
  input  logic [1:0]              req_write,
  input  logic [2*ADDR_WIDTH-1:0] req_addr,
  input  logic [2*DATA_WIDTH-1:0] req_wdata,
  output logic [1:0]              req_ack,
  output logic [1:0]              rsp_valid,
  output logic [DATA_WIDTH-1:0]   rsp_rdata,
  output logic                    rsp_err,
  output logic                    psel,
  output logic                    penable,
  output logic                    pwrite,
  output logic                    pstrb,
  output logic [ADDR_WIDTH-1:0]   paddr,
  output logic [DATA_WIDTH-1:0]   pwdata,
  input  logic [DATA_WIDTH-1:0]   prdata,
  input  logic                    pready,
  input  logic                    pslverr
);

  localparam int CW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } state_e;

  state_e                state_q, state_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic                  last_q, last_d;
  logic                  gnt_q, gnt_d;
  logic                  psel_q, psel_d;
  logic                  penable_q, penable_d;
  logic                  pwrite_q, pwrite_d;
  logic                  pstrb_q, pstrb_d;
  logic [ADDR_WIDTH-1:0] paddr_q, paddr_d;
  logic [DATA_WIDTH-1:0] pwdata_q, pwdata_d;
  logic [1:0]            req_ack_q, req_ack_d;
  logic [1:0]            rsp_valid_q, rsp_valid_d;
  logic [DATA_WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;
  logic                  rsp_err_q, rsp_err_d;

  logic                  any_req;
  logic                  win;
  logic                  win_write;
  logic [ADDR_WIDTH-1:0] win_addr;
  logic [DATA_WIDTH-1:0] win_wdata;
  logic                  timeout_hit;

  // Contention goes to whoever was not served last; a lone requester always wins.
  assign any_req     = |req_valid;
  assign win         = (req_valid == 2'b11) ? ~last_q : req_valid[1];
  assign win_write   = win ? req_write[1] : req_write[0];
  assign win_addr    = win ? req_addr[2*ADDR_WIDTH-1:ADDR_WIDTH] : req_addr[ADDR_WIDTH-1:0];
  assign win_wdata   = win ? req_wdata[2*DATA_WIDTH-1:DATA_WIDTH] : req_wdata[DATA_WIDTH-1:0];
  // cnt_q counts ACCESS cycles already spent, so this is the last allowed wait cycle.
  assign timeout_hit = !pready && (cnt_q == CW'(TIMEOUT - 1));

  // State register; reset abandons any transfer in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state: one SETUP cycle, ACCESS until pready or timeout, back to IDLE.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (any_req) state_d = SETUP;
      SETUP:   state_d = ACCESS;
      ACCESS:  if (pready || timeout_hit) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output and datapath next values; everything leaving the block is registered.
  always_comb begin
    cnt_d       = cnt_q;
    last_d      = last_q;
    gnt_d       = gnt_q;
    psel_d      = psel_q;
    penable_d   = penable_q;
    pwrite_d    = pwrite_q;
    pstrb_d     = pstrb_q;
    paddr_d     = paddr_q;
    pwdata_d    = pwdata_q;
    req_ack_d   = 2'b00;
    rsp_valid_d = 2'b00;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
    case (state_q)
      IDLE: begin
        if (any_req) begin
          gnt_d     = win;
          last_d    = win;
          cnt_d     = '0;
          psel_d    = 1'b1;
          penable_d = 1'b0;
          pwrite_d  = win_write;
          pstrb_d   = win_write;
          paddr_d   = win_addr;
          pwdata_d  = win_write ? win_wdata : '0;
          req_ack_d = {win, ~win};
        end
      end
      SETUP: begin
        penable_d = 1'b1;
        cnt_d     = '0;
      end
      ACCESS: begin
        if (pready) begin
          psel_d      = 1'b0;
          penable_d   = 1'b0;
          rsp_valid_d = {gnt_q, ~gnt_q};
          rsp_rdata_d = pwrite_q ? '0 : prdata;
          rsp_err_d   = pslverr;
        end else if (timeout_hit) begin
          psel_d      = 1'b0;
          penable_d   = 1'b0;
          rsp_valid_d = {gnt_q, ~gnt_q};
          rsp_rdata_d = '0;
          rsp_err_d   = 1'b1;
        end else if (cnt_q != CW'(TIMEOUT)) begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: begin
        psel_d    = 1'b0;
        penable_d = 1'b0;
      end
    endcase
  end

  // Datapath and output registers, cleared asynchronously on reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q       <= '0;
      last_q      <= 1'b1;
      gnt_q       <= 1'b0;
      psel_q      <= 1'b0;
      penable_q   <= 1'b0;
      pwrite_q    <= 1'b0;
      pstrb_q     <= 1'b0;
      paddr_q     <= '0;
      pwdata_q    <= '0;
      req_ack_q   <= 2'b00;
      rsp_valid_q <= 2'b00;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      last_q      <= last_d;
      gnt_q       <= gnt_d;
      psel_q      <= psel_d;
      penable_q   <= penable_d;
      pwrite_q    <= pwrite_d;
      pstrb_q     <= pstrb_d;
      paddr_q     <= paddr_d;
      pwdata_q    <= pwdata_d;
      req_ack_q   <= req_ack_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  assign psel      = psel_q;
  assign penable   = penable_q;
  assign pwrite    = pwrite_q;
  assign pstrb     = pstrb_q;
  assign paddr     = paddr_q;
  assign pwdata    = pwdata_q;
  assign req_ack   = req_ack_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_apb_arb_master.sv
// tb/tb_apb_arb_master.sv - randomized self-checking bench for apb_arb_master
module tb_apb_arb_master;
  localparam int AW = 8;
  localparam int DW = 8;
  localparam int TO = 16;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [1:0]    req_valid, req_write;
  logic [2*AW-1:0] req_addr;
  logic [2*DW-1:0] req_wdata;
  logic [1:0]    req_ack, rsp_valid;
  logic [DW-1:0] rsp_rdata;
  logic          rsp_err;
  logic          psel, penable, pwrite, pstrb;
  logic [AW-1:0] paddr;
  logic [DW-1:0] pwdata;
  logic [DW-1:0] prdata;
  logic          pready, pslverr;

  int vectors = 0;
  int miscompares = 0;

  // Reference state: arbitration pointer, expected memory image, held response.
  logic          last_ref;
  logic [DW-1:0] ref_mem [256];
  logic [DW-1:0] slv_mem [256];
  logic [DW-1:0] last_rdata;
  logic          last_err;

  always #5 clk = ~clk;

  apb_arb_master #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
    .req_ack(req_ack), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .psel(psel), .penable(penable), .pwrite(pwrite), .pstrb(pstrb),
    .paddr(paddr), .pwdata(pwdata), .prdata(prdata), .pready(pready), .pslverr(pslverr)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic set_req(input int idx, input logic wr, input logic [AW-1:0] a, input logic [DW-1:0] d);
    if (idx == 0) begin
      req_write[0] = wr;
      req_addr[AW-1:0] = a;
      req_wdata[DW-1:0] = d;
    end else begin
      req_write[1] = wr;
      req_addr[2*AW-1:AW] = a;
      req_wdata[2*DW-1:DW] = d;
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_psel"},    32'({psel, penable}), 32'h0);
    check_eq({tag, "_pwr"},     32'({pwrite, pstrb}), 32'h0);
    check_eq({tag, "_paddr"},   32'(paddr), 32'h0);
    check_eq({tag, "_pwdata"},  32'(pwdata), 32'h0);
    check_eq({tag, "_ack"},     32'(req_ack), 32'h0);
    check_eq({tag, "_rspv"},    32'(rsp_valid), 32'h0);
    check_eq({tag, "_rsperr"},  32'(rsp_err), 32'h0);
    check_eq({tag, "_rdata"},   32'(rsp_rdata), 32'h0);
  endtask

  // Called at a negedge in an idle cycle with req_valid already non-zero.
  task automatic xfer(input int waits, input bit err, input bit hold_valid, input bit scramble);
    int            w;
    int            acc_cycles;
    int            psel_cycles;
    bit            timeout;
    logic [AW-1:0] e_addr;
    logic [DW-1:0] e_wdata, e_rdata;
    logic          e_write, e_err;
    logic [1:0]    e_onehot;

    if (req_valid == 2'b11) w = last_ref ? 0 : 1;
    else                    w = req_valid[1] ? 1 : 0;
    last_ref   = (w == 1);
    e_onehot   = (w == 1) ? 2'b10 : 2'b01;
    e_addr     = (w == 1) ? req_addr[2*AW-1:AW] : req_addr[AW-1:0];
    e_wdata    = (w == 1) ? req_wdata[2*DW-1:DW] : req_wdata[DW-1:0];
    e_write    = req_write[w];
    timeout    = (waits >= TO);
    acc_cycles = timeout ? TO : waits + 1;
    e_err      = timeout ? 1'b1 : err;
    e_rdata    = (timeout || e_write) ? '0 : ref_mem[e_addr];
    if (!timeout && e_write && !err) ref_mem[e_addr] = e_wdata;

    psel_cycles = 0;
    @(posedge clk); @(negedge clk);
    check_eq("setup_ack",    32'(req_ack), 32'(e_onehot));
    check_eq("setup_ctl",    32'({psel, penable}), 32'(2'b10));
    check_eq("setup_paddr",  32'(paddr), 32'(e_addr));
    check_eq("setup_pwrite", 32'({pwrite, pstrb}), 32'({e_write, e_write}));
    check_eq("setup_pwdata", 32'(pwdata), 32'(e_write ? e_wdata : 8'h00));
    check_eq("setup_rspv",   32'(rsp_valid), 32'h0);
    psel_cycles += int'(psel);
    if (!hold_valid) req_valid[w] = 1'b0;
    if (scramble) set_req(w, 1'($urandom), 8'($urandom), 8'($urandom));

    for (int k = 0; k < acc_cycles; k++) begin
      @(posedge clk); @(negedge clk);
      check_eq("acc_ctl",    32'({psel, penable}), 32'(2'b11));
      check_eq("acc_paddr",  32'(paddr), 32'(e_addr));
      check_eq("acc_pwdata", 32'({pwrite, pstrb, pwdata}), 32'({e_write, e_write, (e_write ? e_wdata : 8'h00)}));
      check_eq("acc_noack",  32'({req_ack, rsp_valid}), 32'h0);
      psel_cycles += int'(psel);
      pready  = (k == acc_cycles - 1) && !timeout;
      pslverr = pready ? err : 1'($urandom);
      prdata  = pready ? slv_mem[paddr] : 8'($urandom);
      if (pready && pwrite && !pslverr) slv_mem[paddr] = pwdata;
    end

    @(posedge clk); @(negedge clk);
    pready  = 1'b0;
    pslverr = 1'b0;
    check_eq("rsp_valid",   32'(rsp_valid), 32'(e_onehot));
    check_eq("rsp_err",     32'(rsp_err), 32'(e_err));
    check_eq("rsp_rdata",   32'(rsp_rdata), 32'(e_rdata));
    check_eq("rsp_psel",    32'({psel, penable}), 32'h0);
    check_eq("psel_cycles", 32'(psel_cycles), 32'(acc_cycles + 1));
    last_rdata = e_rdata;
    last_err   = e_err;
  endtask

  // Quiet cycles: no bus activity, response fields hold.
  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); @(negedge clk);
      check_eq("idle_psel",  32'({psel, penable}), 32'h0);
      check_eq("idle_pulse", 32'({req_ack, rsp_valid}), 32'h0);
      check_eq("idle_rdata", 32'(rsp_rdata), 32'(last_rdata));
      check_eq("idle_err",   32'(rsp_err), 32'(last_err));
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_reset_outputs("rst");
    @(negedge clk);
    rst_n      = 1'b1;
    last_ref   = 1'b1;
    last_rdata = '0;
    last_err   = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    rst_n     = 1'b1;
    req_valid = 2'b00;
    req_write = 2'b00;
    req_addr  = '0;
    req_wdata = '0;
    prdata    = '0;
    pready    = 1'b0;
    pslverr   = 1'b0;
    for (int i = 0; i < 256; i++) begin
      ref_mem[i] = '0;
      slv_mem[i] = '0;
    end
    last_ref   = 1'b1;
    last_rdata = '0;
    last_err   = 1'b0;

    // Asynchronous reset takes effect before any clock edge.
    #2 rst_n = 1'b0;
    #1 check_reset_outputs("por");
    @(negedge clk);
    rst_n = 1'b1;
    idle_cycles(1);

    // Single write, pready on the second ACCESS cycle, then readback.
    set_req(0, 1'b1, 8'h05, 8'hA5);
    req_valid = 2'b01;
    xfer(1, 1'b0, 1'b0, 1'b0);
    idle_cycles(2);
    set_req(0, 1'b0, 8'h05, 8'h00);
    req_valid = 2'b01;
    xfer(0, 1'b0, 1'b0, 1'b0);
    idle_cycles(1);

    // Contention held from reset: grants alternate starting with requester 0.
    req_valid = 2'b11;
    set_req(0, 1'b1, 8'h10, 8'h11);
    set_req(1, 1'b1, 8'h20, 8'h22);
    do_reset();
    for (int i = 0; i < 4; i++) xfer(int'($urandom_range(0, 2)), 1'b0, 1'b1, 1'b1);
    req_valid = 2'b00;
    idle_cycles(1);

    // Slave never ready: abort after the full ACCESS budget.
    set_req(1, 1'b0, 8'h05, 8'h00);
    req_valid = 2'b10;
    xfer(TO + 4, 1'b0, 1'b0, 1'b0);
    idle_cycles(2);

    // Slave error on a write, then a clean read clears the status.
    set_req(0, 1'b1, 8'h40, 8'h3C);
    req_valid = 2'b01;
    xfer(0, 1'b1, 1'b0, 1'b0);
    idle_cycles(1);
    set_req(0, 1'b0, 8'h40, 8'h00);
    req_valid = 2'b01;
    xfer(2, 1'b0, 1'b0, 1'b0);
    idle_cycles(1);

    // Randomized traffic with waiting requesters, held valids and occasional timeouts.
    for (int i = 0; i < 40; i++) begin
      for (int r = 0; r < 2; r++)
        if (!req_valid[r]) set_req(r, 1'($urandom), 8'($urandom_range(0, 15)), 8'($urandom));
      req_valid = req_valid | 2'($urandom);
      if (req_valid == 2'b00) req_valid = 2'b01;
      xfer(($urandom_range(0, 9) == 0) ? TO : int'($urandom_range(0, 4)),
           1'($urandom_range(0, 4) == 0), 1'($urandom), 1'b1);
      if ($urandom_range(0, 3) == 0) begin
        req_valid = 2'b00;
        idle_cycles(int'($urandom_range(1, 2)));
      end
    end
    req_valid = 2'b00;
    idle_cycles(1);

    // Reset in the middle of ACCESS: bus drops at once, no response is produced.
    set_req(0, 1'b1, 8'h33, 8'h5A);
    req_valid = 2'b01;
    @(posedge clk); @(negedge clk);
    check_eq("mid_ack", 32'(req_ack), 32'(2'b01));
    req_valid = 2'b00;
    repeat (2) begin
      @(posedge clk); @(negedge clk);
    end
    check_eq("mid_access", 32'({psel, penable}), 32'(2'b11));
    rst_n = 1'b0;
    #1;
    check_reset_outputs("mid_rst");
    @(posedge clk); @(negedge clk);
    check_eq("mid_rst_rspv", 32'(rsp_valid), 32'h0);
    rst_n      = 1'b1;
    last_ref   = 1'b1;
    last_rdata = '0;
    last_err   = 1'b0;
    idle_cycles(1);
    set_req(1, 1'b0, 8'h05, 8'h00);
    req_valid = 2'b10;
    xfer(0, 1'b0, 1'b0, 1'b0);
    set_req(0, 1'b0, 8'h05, 8'h00);
    set_req(1, 1'b1, 8'h77, 8'h99);
    req_valid = 2'b11;
    xfer(1, 1'b0, 1'b0, 1'b0);
    xfer(0, 1'b0, 1'b0, 1'b0);
    idle_cycles(2);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
